// File: rtl/mul32_pkg.sv
// Shared types and constants for the sequential 32x32 shift-and-add multiplier.
package mul32_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul32_seq_ctrl_adder.sv
// Structural 32-bit ripple-carry adder (Full_Adder_32bit), shared by the arithmetic datapath.
module Full_Adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  logic [32:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[32];

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Sequential 32x32->64 unsigned shift-and-add multiplier, one adder pass per cycle.
// Optional MUL_ZERO_BYPASS_EN: zero operands finish in one cycle with product 0.
module mul32_seq_ctrl #(
  parameter int WIDTH = mul32_pkg::WIDTH,
  parameter int CNT_W = mul32_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import mul32_pkg::*;

  if (WIDTH != 32) begin : g_bad_width
    $error("mul32_seq_ctrl: WIDTH must be 32 to match Full_Adder_32bit");
  end
  if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
    $error("mul32_seq_ctrl: CNT_W too narrow to count WIDTH iterations");
  end

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   shifted;
  logic                 zero_op;

  assign add_b = lo_q[0] ? mcand_q : '0;

  Full_Adder_32bit u_adder (
    .A    (hi_q),
    .B    (add_b),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // 65-bit {cout,sum,lo} shifted right by one; the dropped bit is the consumed multiplier bit.
  assign shifted = {cout, sum, lo_q[WIDTH-1:1]};

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = RUN;
          if (zero_op) begin
            lo_d      = '0;
            product_d = '0;
            state_d   = DONE;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        {hi_d, lo_d} = shifted;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d   = DONE;
          product_d = shifted;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl: latency, carry capture, ignored starts, reset abort, back-to-back.
module tb_mul32_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks;
  int failures;
  int cyc;
  int e0;

`ifdef MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT  = 0;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = 32;
  localparam int ZERO_BUSY = 32;
`endif

  mul32_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // driver: present operands so they are sampled at the next edge (E0)
  task automatic accept(input logic [31:0] av, input logic [31:0] bv, input logic hold);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (!hold) start = 1'b0;
  endtask

  // driver: step edges until done, counting busy samples; bounded
  task automatic wait_done(output int lat, output int bcnt, output logic [63:0] prod);
    int n;
    n    = 0;
    bcnt = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      n++;
    end
    lat  = cyc - e0;
    prod = product;
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL wait_done: no done pulse within 200 cycles");
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (product !== 64'd0) begin
      failures++;
      $display("FAIL reset_product: got %h expected 0", product);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic [63:0] p;
    accept(32'd3, 32'd5, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_e0: got %b expected 1", busy);
    end
    wait_done(lat, bcnt, p);
    checks++;
    if (lat !== 32) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected 32", lat);
    end
    checks++;
    if (bcnt !== 32) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d expected 32", bcnt);
    end
    checks++;
    if (p !== 64'h0000_0000_0000_000F) begin
      failures++;
      $display("FAIL basic_product: got %h expected 000000000000000f", p);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL basic_done_falls: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (product !== 64'h0000_0000_0000_000F) begin
      failures++;
      $display("FAIL basic_product_hold: got %h expected 000000000000000f", product);
    end
  endtask

  task automatic test_max();
    int lat, bcnt;
    logic [63:0] p;
    accept(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat, bcnt, p);
    checks++;
    if (p !== 64'hFFFF_FFFE_0000_0001 || lat !== 32) begin
      failures++;
      $display("FAIL max_product: got %h lat %0d expected fffffffe00000001 lat 32", p, lat);
    end
  endtask

  task automatic test_patterns();
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [63:0] tp [5];
    int lat, bcnt;
    logic [63:0] p;
    ta[0] = 32'h8000_0000; tb[0] = 32'd2;          tp[0] = 64'h0000_0001_0000_0000;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'd2;          tp[1] = 64'h0000_0001_FFFF_FFFE;
    ta[2] = 32'd1;         tb[2] = 32'hFFFF_FFFF;  tp[2] = 64'h0000_0000_FFFF_FFFF;
    ta[3] = 32'h0000_FFFF; tb[3] = 32'h0000_FFFF;  tp[3] = 64'h0000_0000_FFFE_0001;
    ta[4] = 32'd1000;      tb[4] = 32'd1000;       tp[4] = 64'd1000000;
    for (int i = 0; i < 5; i++) begin
      accept(ta[i], tb[i], 1'b0);
      wait_done(lat, bcnt, p);
      checks++;
      if (p !== tp[i] || lat !== 32) begin
        failures++;
        $display("FAIL pattern_%0d: got %h lat %0d expected %h lat 32", i, p, lat, tp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_start();
    int lat, bcnt;
    logic [63:0] p;
    accept(32'd3, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt, p);
    checks++;
    if (p !== 64'h0000_0000_0000_000F || lat !== 32) begin
      failures++;
      $display("FAIL ignore_start: got %h lat %0d expected 000000000000000f lat 32", p, lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL ignore_start_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, dcnt;
    logic [63:0] p;
    accept(32'd4, 32'd6, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst  = 1'b1;
    dcnt = 0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || product !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid_abort: busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcnt++;
      if (i == 2) rst = 1'b0;
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dcnt);
    end
    accept(32'd2, 32'd9, 1'b0);
    wait_done(lat, bcnt, p);
    checks++;
    if (p !== 64'h12 || lat !== 32) begin
      failures++;
      $display("FAIL reset_mid_fresh: got %h lat %0d expected 0000000000000012 lat 32", p, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, t_prev;
    logic [63:0] p;
    accept(32'h0001_0000, 32'h0001_0000, 1'b1);
    wait_done(lat, bcnt, p);
    t_prev = cyc;
    checks++;
    if (p !== 64'h0000_0001_0000_0000 || lat !== 32) begin
      failures++;
      $display("FAIL b2b_first: got %h lat %0d expected 0000000100000000 lat 32", p, lat);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      wait_done(lat, bcnt, p);
      checks++;
      if (p !== 64'h0000_0001_0000_0000 || (cyc - t_prev) !== 33) begin
        failures++;
        $display("FAIL b2b_repeat_%0d: got %h interval %0d expected 0000000100000000 interval 33",
                 k, p, cyc - t_prev);
      end
      t_prev = cyc;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_stop: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_zero();
    int lat, bcnt;
    logic [63:0] p;
    accept(32'd0, 32'h1234, 1'b0);
    wait_done(lat, bcnt, p);
    checks++;
    if (p !== 64'd0 || lat !== ZERO_LAT || bcnt !== ZERO_BUSY) begin
      failures++;
      $display("FAIL zero_operand: got %h lat %0d busy %0d expected 0 lat %0d busy %0d",
               p, lat, bcnt, ZERO_LAT, ZERO_BUSY);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    e0       = 0;
    test_reset();
    test_basic();
    test_max();
    test_patterns();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
